// File: rtl/watch_core.sv
// Synchronous HH:MM:SS BCD time-of-day counter with seconds prescaler,
// selectable 12/24-hour display and a field-by-field time-set state machine.
module watch_core #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter bit          MODE24   = 1'b0,
  parameter int unsigned DIV_W    = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_resume,
  input  logic       stop,
  input  logic       setTime,
  input  logic       inc,
  output logic [3:0] hr1,
  output logic [3:0] hr0,
  output logic [3:0] min1,
  output logic [3:0] min0,
  output logic [3:0] sec1,
  output logic [3:0] sec0,
  output logic       pm,
  output logic       running,
  output logic [1:0] set_field
);

  typedef enum logic [2:0] {StStopped, StRun, StSetHr, StSetMin, StSetSec} state_e;

  localparam logic [3:0] HrRst1 = MODE24 ? 4'd0 : 4'd1;
  localparam logic [3:0] HrRst0 = MODE24 ? 4'd0 : 4'd2;
  localparam logic [DIV_W-1:0] DivLast = DIV_W'(TICK_DIV - 1);

  state_e           r_state;
  logic [DIV_W-1:0] r_div;
  logic [3:0]       r_hr1, r_hr0, r_min1, r_min0, r_sec1, r_sec0;
  logic             r_pm, r_running;
  logic [1:0]       r_set_field;

  logic       w_tick, w_sec_wrap, w_min_wrap, w_hr_toggle;
  logic [3:0] w_sec1_n, w_sec0_n, w_min1_n, w_min0_n, w_hr1_n, w_hr0_n;

  assign w_tick     = (r_div == DivLast);
  assign w_sec_wrap = (r_sec1 == 4'd5) && (r_sec0 == 4'd9);
  assign w_min_wrap = (r_min1 == 4'd5) && (r_min0 == 4'd9);

  always_comb begin
    w_sec1_n = r_sec1;
    w_sec0_n = r_sec0 + 4'd1;
    if (r_sec0 == 4'd9) begin
      w_sec0_n = 4'd0;
      w_sec1_n = w_sec_wrap ? 4'd0 : r_sec1 + 4'd1;
    end
    w_min1_n = r_min1;
    w_min0_n = r_min0 + 4'd1;
    if (r_min0 == 4'd9) begin
      w_min0_n = 4'd0;
      w_min1_n = w_min_wrap ? 4'd0 : r_min1 + 4'd1;
    end
  end

  // Hour successor; in 12-hour mode 11 -> 12 flips pm and 12 -> 01 does not.
  always_comb begin
    w_hr_toggle = 1'b0;
    w_hr1_n     = r_hr1;
    w_hr0_n     = r_hr0 + 4'd1;
    if (MODE24) begin
      if (r_hr1 == 4'd2 && r_hr0 == 4'd3) begin
        w_hr1_n = 4'd0;
        w_hr0_n = 4'd0;
      end else if (r_hr0 == 4'd9) begin
        w_hr1_n = r_hr1 + 4'd1;
        w_hr0_n = 4'd0;
      end
    end else begin
      if (r_hr1 == 4'd1 && r_hr0 == 4'd1) begin
        w_hr0_n     = 4'd2;
        w_hr_toggle = 1'b1;
      end else if (r_hr1 == 4'd1 && r_hr0 == 4'd2) begin
        w_hr1_n = 4'd0;
        w_hr0_n = 4'd1;
      end else if (r_hr0 == 4'd9) begin
        w_hr1_n = 4'd1;
        w_hr0_n = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StStopped;
      r_div       <= '0;
      r_hr1       <= HrRst1;
      r_hr0       <= HrRst0;
      r_min1      <= 4'd0;
      r_min0      <= 4'd0;
      r_sec1      <= 4'd0;
      r_sec0      <= 4'd0;
      r_pm        <= 1'b0;
      r_running   <= 1'b0;
      r_set_field <= 2'd0;
    end else begin
      case (r_state)
        StStopped: begin
          if (setTime) begin
            r_state     <= StSetHr;
            r_div       <= '0;
            r_set_field <= 2'd1;
          end else if (start_resume) begin
            r_state   <= StRun;
            r_running <= 1'b1;
          end
        end
        StRun: begin
          if (setTime) begin
            r_state     <= StSetHr;
            r_div       <= '0;
            r_running   <= 1'b0;
            r_set_field <= 2'd1;
          end else if (stop) begin
            r_state   <= StStopped;
            r_running <= 1'b0;
          end else if (w_tick) begin
            // Full carry chain resolves on this single edge.
            r_div  <= '0;
            r_sec1 <= w_sec1_n;
            r_sec0 <= w_sec0_n;
            if (w_sec_wrap) begin
              r_min1 <= w_min1_n;
              r_min0 <= w_min0_n;
              if (w_min_wrap) begin
                r_hr1 <= w_hr1_n;
                r_hr0 <= w_hr0_n;
                if (w_hr_toggle) r_pm <= ~r_pm;
              end
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        StSetHr: begin
          if (setTime) begin
            r_state     <= StSetMin;
            r_set_field <= 2'd2;
          end else if (inc) begin
            r_hr1 <= w_hr1_n;
            r_hr0 <= w_hr0_n;
            if (w_hr_toggle) r_pm <= ~r_pm;
          end
        end
        StSetMin: begin
          if (setTime) begin
            r_state     <= StSetSec;
            r_set_field <= 2'd3;
          end else if (inc) begin
            r_min1 <= w_min1_n;
            r_min0 <= w_min0_n;
          end
        end
        StSetSec: begin
          if (setTime) begin
            r_state     <= StStopped;
            r_set_field <= 2'd0;
          end else if (inc) begin
            r_sec1 <= w_sec1_n;
            r_sec0 <= w_sec0_n;
          end
        end
        default: begin
          r_state     <= StStopped;
          r_running   <= 1'b0;
          r_set_field <= 2'd0;
        end
      endcase
    end
  end

  assign hr1       = r_hr1;
  assign hr0       = r_hr0;
  assign min1      = r_min1;
  assign min0      = r_min0;
  assign sec1      = r_sec1;
  assign sec0      = r_sec0;
  assign pm        = r_pm;
  assign running   = r_running;
  assign set_field = r_set_field;

endmodule

// File: tb/tb_watch_core.sv
// Bench for watch_core: a 12-hour and a 24-hour instance share stimulus and are
// compared against a seconds-of-day reference model.
module tb_watch_core;

  localparam int TD = 4;
  localparam int MStop = 0, MRun = 1, MSetHr = 2, MSetMin = 3, MSetSec = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start_resume = 1'b0, stop = 1'b0, setTime = 1'b0, inc = 1'b0;

  logic [3:0] a_hr1, a_hr0, a_min1, a_min0, a_sec1, a_sec0;
  logic       a_pm, a_running;
  logic [1:0] a_set_field;
  logic [3:0] b_hr1, b_hr0, b_min1, b_min0, b_sec1, b_sec0;
  logic       b_pm, b_running;
  logic [1:0] b_set_field;

  int checks = 0;
  int errors = 0;
  int m_state = MStop;
  int m_t = 0;
  int m_div = 0;

  always #5 clk = ~clk;

  watch_core #(.TICK_DIV(TD), .MODE24(1'b0), .DIV_W(3)) u_dut12 (
    .clk(clk), .reset(reset), .start_resume(start_resume), .stop(stop),
    .setTime(setTime), .inc(inc),
    .hr1(a_hr1), .hr0(a_hr0), .min1(a_min1), .min0(a_min0), .sec1(a_sec1), .sec0(a_sec0),
    .pm(a_pm), .running(a_running), .set_field(a_set_field)
  );

  watch_core #(.TICK_DIV(TD), .MODE24(1'b1), .DIV_W(3)) u_dut24 (
    .clk(clk), .reset(reset), .start_resume(start_resume), .stop(stop),
    .setTime(setTime), .inc(inc),
    .hr1(b_hr1), .hr0(b_hr0), .min1(b_min1), .min0(b_min0), .sec1(b_sec1), .sec0(b_sec0),
    .pm(b_pm), .running(b_running), .set_field(b_set_field)
  );

  logic [27:0] obs12, obs24;
  assign obs12 = {a_hr1, a_hr0, a_min1, a_min0, a_sec1, a_sec0, a_pm, a_running, a_set_field};
  assign obs24 = {b_hr1, b_hr0, b_min1, b_min0, b_sec1, b_sec0, b_pm, b_running, b_set_field};

  // Display view of a seconds-of-day value.
  function automatic logic [27:0] expect_vec(input bit mode24, input int t, input int st);
    int h, hd, m, s;
    logic p, r;
    logic [1:0] sf;
    h  = t / 3600;
    m  = (t / 60) % 60;
    s  = t % 60;
    hd = mode24 ? h : ((h % 12 == 0) ? 12 : h % 12);
    p  = mode24 ? 1'b0 : (h >= 12);
    r  = (st == MRun);
    sf = (st == MSetHr) ? 2'd1 : (st == MSetMin) ? 2'd2 : (st == MSetSec) ? 2'd3 : 2'd0;
    return {4'(hd / 10), 4'(hd % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
            p, r, sf};
  endfunction

  task automatic model_step(input bit a, input bit b, input bit c, input bit d);
    int f;
    case (m_state)
      MStop: begin
        if (c) begin m_state = MSetHr; m_div = 0; end
        else if (a) m_state = MRun;
      end
      MRun: begin
        if (c) begin m_state = MSetHr; m_div = 0; end
        else if (b) m_state = MStop;
        else if (m_div == TD - 1) begin m_div = 0; m_t = (m_t + 1) % 86400; end
        else m_div++;
      end
      MSetHr: begin
        if (c) m_state = MSetMin;
        else if (d) m_t = (m_t + 3600) % 86400;
      end
      MSetMin: begin
        if (c) m_state = MSetSec;
        else if (d) begin f = (m_t / 60) % 60; m_t = m_t + (((f + 1) % 60) - f) * 60; end
      end
      default: begin
        if (c) m_state = MStop;
        else if (d) begin f = m_t % 60; m_t = m_t + ((f + 1) % 60) - f; end
      end
    endcase
  endtask

  task automatic check_model(input string tag);
    logic [27:0] e12, e24;
    e12 = expect_vec(1'b0, m_t, m_state);
    e24 = expect_vec(1'b1, m_t, m_state);
    checks += 2;
    assert (obs12 === e12) else begin
      errors++;
      $error("FAIL %s dut12 got %h want %h", tag, obs12, e12);
    end
    assert (obs24 === e24) else begin
      errors++;
      $error("FAIL %s dut24 got %h want %h", tag, obs24, e24);
    end
  endtask

  task automatic check_const(input string tag, input logic [27:0] w12, input logic [27:0] w24);
    checks += 2;
    assert (obs12 === w12) else begin
      errors++;
      $error("FAIL %s dut12 got %h want %h", tag, obs12, w12);
    end
    assert (obs24 === w24) else begin
      errors++;
      $error("FAIL %s dut24 got %h want %h", tag, obs24, w24);
    end
  endtask

  task automatic step(input bit a, input bit b, input bit c, input bit d, input string tag);
    start_resume = a; stop = b; setTime = c; inc = d;
    @(posedge clk);
    model_step(a, b, c, d);
    #1;
    start_resume = 1'b0; stop = 1'b0; setTime = 1'b0; inc = 1'b0;
    check_model(tag);
  endtask

  // Asserted between edges so the check observes the asynchronous path.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    m_state = MStop; m_t = 0; m_div = 0;
    #1;
    check_model(tag);
    check_const(tag, 28'h1200000, 28'h0000000);
    #2;
    reset = 1'b1;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    int n;
    step(0, 0, 1, 0, "set_enter");
    n = (h - m_t / 3600 + 24) % 24;
    repeat (n) step(0, 0, 0, 1, "set_hr_inc");
    step(0, 0, 1, 0, "set_to_min");
    n = (m - (m_t / 60) % 60 + 60) % 60;
    repeat (n) step(0, 0, 0, 1, "set_min_inc");
    step(0, 0, 1, 0, "set_to_sec");
    n = (s - m_t % 60 + 60) % 60;
    repeat (n) step(0, 0, 0, 1, "set_sec_inc");
    step(0, 0, 1, 0, "set_exit");
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset("reset_initial");

    // 240 cycles of RUN at TD=4 is exactly one minute.
    step(1, 0, 0, 0, "start");
    repeat (240) step(0, 0, 0, 0, "run_minute");
    check_const("one_minute", 28'h1201004, 28'h0001004);

    // Stop with a partial second pending, then resume.
    step(0, 0, 0, 0, "run_p1");
    step(0, 0, 0, 0, "run_p2");
    step(0, 1, 0, 0, "stop_p2");
    repeat (50) step(0, 0, 0, 0, "stopped_hold");
    check_const("stopped_hold", 28'h1201000, 28'h0001000);
    step(1, 0, 0, 0, "resume");
    step(0, 0, 0, 0, "resume_c1");
    check_const("resume_c1", 28'h1201004, 28'h0001004);
    step(0, 0, 0, 0, "resume_c2");
    check_const("resume_tick", 28'h1201014, 28'h0001014);

    // 11:59:59 am -> 12:00:00 pm
    step(0, 1, 0, 0, "stop_a");
    set_time(11, 59, 59);
    check_const("set_115959", 28'h1159590, 28'h1159590);
    step(1, 0, 0, 0, "start_b");
    repeat (TD) step(0, 0, 0, 0, "tick_noon");
    check_const("noon", 28'h120000C, 28'h1200004);

    // 12:59:59 pm -> 01:00:00 pm
    step(0, 1, 0, 0, "stop_b");
    set_time(12, 59, 59);
    step(1, 0, 0, 0, "start_c");
    repeat (TD) step(0, 0, 0, 0, "tick_one");
    check_const("one_pm", 28'h010000C, 28'h1300004);

    // 23:59:59 -> midnight, full carry chain
    step(0, 1, 0, 0, "stop_c");
    set_time(23, 59, 59);
    step(1, 0, 0, 0, "start_d");
    repeat (TD) step(0, 0, 0, 0, "tick_midnight");
    check_const("midnight", 28'h1200004, 28'h0000004);

    // Field increments wrap without carry.
    do_reset("reset_b");
    step(0, 0, 1, 0, "enter_hr");
    repeat (3) step(0, 0, 0, 1, "hr_inc");
    check_const("hr_3", 28'h0300001, 28'h0300001);
    step(0, 0, 1, 0, "to_min");
    repeat (61) step(0, 0, 0, 1, "min_inc");
    check_const("min_wrap", 28'h0301002, 28'h0301002);
    step(0, 0, 1, 0, "to_sec");
    step(0, 0, 1, 0, "to_stop");
    check_const("set_exit", 28'h0301000, 28'h0301000);

    // Asynchronous reset mid-RUN and mid-SET_MIN.
    step(1, 0, 0, 0, "start_e");
    repeat (9) step(0, 0, 0, 0, "run_e");
    #2;
    do_reset("reset_mid_run");
    step(0, 0, 1, 0, "enter_f");
    step(0, 0, 1, 0, "to_min_f");
    step(0, 0, 0, 1, "min_inc_f");
    step(0, 0, 0, 1, "min_inc_f");
    do_reset("reset_mid_set");

    // setTime outranks stop in RUN.
    step(1, 0, 0, 0, "start_g");
    step(0, 0, 0, 0, "run_g");
    step(0, 0, 0, 0, "run_g");
    step(0, 1, 1, 0, "set_over_stop");
    check_const("set_over_stop", 28'h1200001, 28'h0000001);

    // Random pulse soup with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset("rand_reset");
      end else begin
        step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
             $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0, "random");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
